cdc_reg_bridge: RTL

- Application-side stage directly downstream of the USB CDC function's byte streams.
- Consumes host bytes from the CDC OUT stream, decodes a 2/3-byte command protocol, and performs single register reads/writes on a simple request/acknowledge bus.
- Returns one response byte per command into the CDC IN stream.
- Lets the host read and write on-chip control registers over a virtual COM port.

---
 rtl/cdc_reg_bridge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cdc_reg_bridge.sv
// Host byte-command to register-bus bridge behind a USB CDC function.
// Decodes 'W addr data' / 'R addr' commands, runs one bus access, returns one response byte.
module cdc_reg_bridge #(
  parameter int unsigned BYTE_TIMEOUT = 'd1200000,
  parameter int unsigned BUS_TIMEOUT  = 'd255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       configured_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  output logic       bus_we_o,
  output logic       bus_req_o,
  input  logic [7:0] bus_rdata_i,
  input  logic       bus_ack_i,
  output logic [7:0] err_count_o
);

  localparam int unsigned BCW = $clog2(BYTE_TIMEOUT) + 1;
  localparam int unsigned UCW = $clog2(BUS_TIMEOUT) + 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTE_TIMEOUT - 1);
  localparam logic [UCW-1:0] BUS_LAST  = UCW'(BUS_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  logic [2:0]     state_q, state_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           we_q, we_d;
  logic           req_q, req_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     err_q, err_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [UCW-1:0] bus_cnt_q, bus_cnt_d;
  logic           err_inc;
  logic           rx_fire;

  // While unconfigured the stream is drained so stale host bytes never form a command.
  assign rx_ready_o = ~rst_i & (~configured_i | (state_q == S_IDLE) |
                                (state_q == S_ADDR) | (state_q == S_DATA));
  assign rx_fire    = rx_valid_i & rx_ready_o;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    req_d      = req_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    byte_cnt_d = byte_cnt_q;
    bus_cnt_d  = bus_cnt_q;
    err_inc    = 1'b0;

    if (!configured_i) begin
      state_d    = S_IDLE;
      req_d      = 1'b0;
      tx_valid_d = 1'b0;
      byte_cnt_d = '0;
      bus_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          byte_cnt_d = '0;
          if (rx_fire) begin
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              we_d    = (rx_data_i == OP_WRITE);
              state_d = S_ADDR;
            end else begin
              tx_data_d  = RSP_NAK;
              tx_valid_d = 1'b1;
              err_inc    = 1'b1;
              state_d    = S_RESP;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_fire) begin
            byte_cnt_d = '0;
            if (state_q == S_ADDR) addr_d = rx_data_i;
            else                   wdata_d = rx_data_i;
            if (state_q == S_ADDR && we_q) begin
              state_d = S_DATA;
            end else begin
              req_d     = 1'b1;
              bus_cnt_d = '0;
              state_d   = S_BUS;
            end
          end else if (byte_cnt_q == BYTE_LAST) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
        S_BUS: begin
          // An ack on the final counted cycle still wins over the timeout.
          if (bus_ack_i) begin
            req_d      = 1'b0;
            tx_data_d  = we_q ? RSP_ACK : bus_rdata_i;
            tx_valid_d = 1'b1;
            state_d    = S_RESP;
          end else if (bus_cnt_q == BUS_LAST) begin
            req_d      = 1'b0;
            tx_data_d  = RSP_NAK;
            tx_valid_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = S_RESP;
          end else begin
            bus_cnt_d = bus_cnt_q + UCW'(1);
          end
        end
        S_RESP: begin
          if (tx_ready_i) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: begin
          req_d      = 1'b0;
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      endcase
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= '0;
      byte_cnt_q <= '0;
      bus_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      req_q      <= req_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      byte_cnt_q <= byte_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_we_o    = we_q;
  assign bus_req_o   = req_q;
  assign err_count_o = err_q;

endmodule
